sram_port_arbiter: RTL and testbench

//   Shares one single-ported unified SRAM between the fetch stage (inst side) and the MEM stage (data side).

---
 rtl/sram_port_arbiter.sv | 92 +++++++++
 tb/tb_sram_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-ported SRAM between fetch (inst) and MEM (data) requesters.
// Data wins by default; a saturating starvation counter forces an inst grant after STARVE_MAX data grants.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ready,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ready,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]         starve_cnt;
  logic               starved;
  logic               gnt_i;
  logic               gnt_d;
  logic               rsp_d;
  // {vld, owner} per stage kept as two one-hot bits so the tail drives rvalid straight from a flop
  logic [MEM_LAT-1:0] pipe_i;
  logic [MEM_LAT-1:0] pipe_d;

  always_comb begin
    starved = inst_req && (starve_cnt == STARVE_LIM);
    gnt_d   = data_req && !starved && !reset;
    gnt_i   = inst_req && !gnt_d && !reset;
    rsp_d   = gnt_d && (data_wen == '0);
  end

  always_comb begin
    inst_ready = gnt_i;
    data_ready = gnt_d;
    mem_en     = gnt_i || gnt_d;
    mem_wen    = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (gnt_d) begin
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (gnt_i) begin
      mem_addr  = inst_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      pipe_i     <= '0;
      pipe_d     <= '0;
    end else begin
      if (gnt_d && inst_req) begin
        if (starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
      pipe_i[0] <= gnt_i;
      pipe_d[0] <= rsp_d;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        pipe_i[i] <= pipe_i[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  always_comb begin
    inst_rvalid = pipe_i[MEM_LAT-1];
    data_rvalid = pipe_d[MEM_LAT-1];
    inst_rdata  = inst_rvalid ? mem_rdata : '0;
    data_rdata  = data_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3.
module tb_sram_port_arbiter;

  typedef struct {
    int          dut;
    bit          own;
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          t1_cyc = -1;
  int          checks = 0;
  int          errors = 0;
  rsp_t        sb[$];
  logic [31:0] mem_rdata = '0;

  logic        a_reset, a_inst_req, a_inst_ready, a_inst_rvalid, a_data_req, a_data_ready, a_data_rvalid, a_mem_en;
  logic [31:0] a_inst_addr, a_inst_rdata, a_data_addr, a_data_wdata, a_data_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_data_wen, a_mem_wen;
  logic        b_reset, b_inst_req, b_inst_ready, b_inst_rvalid, b_data_req, b_data_ready, b_data_rvalid, b_mem_en;
  logic [31:0] b_inst_addr, b_inst_rdata, b_data_addr, b_data_wdata, b_data_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_data_wen, b_mem_wen;

  sram_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clk(clk), .reset(a_reset),
    .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_ready(a_inst_ready),
    .inst_rvalid(a_inst_rvalid), .inst_rdata(a_inst_rdata),
    .data_req(a_data_req), .data_wen(a_data_wen), .data_addr(a_data_addr), .data_wdata(a_data_wdata),
    .data_ready(a_data_ready), .data_rvalid(a_data_rvalid), .data_rdata(a_data_rdata),
    .mem_en(a_mem_en), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  sram_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .reset(b_reset),
    .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_ready(b_inst_ready),
    .inst_rvalid(b_inst_rvalid), .inst_rdata(b_inst_rdata),
    .data_req(b_data_req), .data_wen(b_data_wen), .data_addr(b_data_addr), .data_wdata(b_data_wdata),
    .data_ready(b_data_ready), .data_rvalid(b_data_rvalid), .data_rdata(b_data_rdata),
    .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM read data is a pure function of the cycle number, so expected rdata is known at grant time
  function automatic logic [31:0] exp_rdata(input int c);
    if (c == t1_cyc) return 32'h2401_0001;
    return 32'hA500_0000 | 32'(c);
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    mem_rdata = exp_rdata(cyc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic iv, input logic [31:0] id, input logic dv, input logic [31:0] dd);
    int idx = -1;
    foreach (sb[j]) if (idx < 0 && sb[j].dut == k) idx = j;
    if (!iv) chk("idle_inst_rdata", id, 0);
    if (!dv) chk("idle_data_rdata", dd, 0);
    if (iv || dv) begin
      if (idx < 0) begin
        chk("unexpected_rvalid", {iv, dv}, 0);
      end else begin
        chk("rsp_owner", {dv, iv}, {sb[idx].own, !sb[idx].own});
        chk("rsp_rdata", iv ? id : dd, sb[idx].data);
        chk("rsp_cycle", cyc, sb[idx].due);
        sb.delete(idx);
      end
    end else if (idx >= 0 && sb[idx].due <= cyc) begin
      chk("rvalid_due", {dv, iv}, {sb[idx].own, !sb[idx].own});
      sb.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_inst_rvalid, a_inst_rdata, a_data_rvalid, a_data_rdata);
    mon(1, b_inst_rvalid, b_inst_rdata, b_data_rvalid, b_data_rdata);
  end

  task automatic cyc_step(input int k, input bit ireq, input logic [31:0] iaddr,
                          input bit dreq, input logic [3:0] dwen, input logic [31:0] daddr,
                          input logic [31:0] dwd, input bit egi, input bit egd, input string tag);
    logic ir, dr, me;
    logic [3:0] mw;
    logic [31:0] ma, md;
    int lat;
    @(posedge clk);
    #1;
    if (k == 0) begin
      a_inst_req = ireq; a_inst_addr = iaddr; a_data_req = dreq;
      a_data_wen = dwen; a_data_addr = daddr; a_data_wdata = dwd;
    end else begin
      b_inst_req = ireq; b_inst_addr = iaddr; b_data_req = dreq;
      b_data_wen = dwen; b_data_addr = daddr; b_data_wdata = dwd;
    end
    #2;
    if (k == 0) begin
      ir = a_inst_ready; dr = a_data_ready; me = a_mem_en; mw = a_mem_wen; ma = a_mem_addr; md = a_mem_wdata;
      lat = 1;
    end else begin
      ir = b_inst_ready; dr = b_data_ready; me = b_mem_en; mw = b_mem_wen; ma = b_mem_addr; md = b_mem_wdata;
      lat = 3;
    end
    chk({tag, "_inst_ready"}, ir, egi);
    chk({tag, "_data_ready"}, dr, egd);
    chk({tag, "_mem_en"}, me, egi | egd);
    chk({tag, "_mem_addr"}, ma, egd ? daddr : (egi ? iaddr : 32'h0));
    chk({tag, "_mem_wen"}, mw, egd ? dwen : 4'h0);
    chk({tag, "_mem_wdata"}, md, egd ? dwd : 32'h0);
    if (egi) sb.push_back('{k, 1'b0, exp_rdata(cyc + lat), cyc + lat});
    if (egd && dwen == 4'h0) sb.push_back('{k, 1'b1, exp_rdata(cyc + lat), cyc + lat});
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) cyc_step(k, 0, '0, 0, '0, '0, '0, 0, 0, "idle");
  endtask

  initial begin
    a_reset = 1; a_inst_req = 0; a_inst_addr = '0; a_data_req = 0; a_data_wen = '0; a_data_addr = '0; a_data_wdata = '0;
    b_reset = 1; b_inst_req = 0; b_inst_addr = '0; b_data_req = 0; b_data_wen = '0; b_data_addr = '0; b_data_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    a_inst_req = 1; a_inst_addr = 32'h1234_5678; a_data_req = 1; a_data_addr = 32'h8765_4320;
    #2;
    chk("reset_inst_ready", a_inst_ready, 0);
    chk("reset_data_ready", a_data_ready, 0);
    chk("reset_mem_en", a_mem_en, 0);
    chk("reset_mem_addr", a_mem_addr, 0);
    chk("reset_rvalid", {a_inst_rvalid, a_data_rvalid}, 0);
    @(posedge clk);
    #1;
    a_inst_req = 0; a_data_req = 0; a_reset = 0; b_reset = 0;

    // T1: single fetch, MEM_LAT=1
    t1_cyc = cyc + 2;
    cyc_step(0, 1, 32'hBFC0_0000, 0, '0, '0, '0, 1, 0, "t1");
    idle(0, 2);

    // T2: simultaneous read requests; data first, inst next cycle
    cyc_step(0, 1, 32'h0000_1000, 1, 4'h0, 32'h8000_0004, '0, 0, 1, "t2_c0");
    cyc_step(0, 1, 32'h0000_1000, 0, 4'h0, '0, '0, 1, 0, "t2_c1");
    idle(0, 2);

    // T3: store is fire-and-forget; store beats a concurrent fetch
    cyc_step(0, 0, '0, 1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1, "t3_wr");
    idle(0, 2);
    cyc_step(0, 1, 32'h0000_2000, 1, 4'h3, 32'h8000_0020, 32'h0BAD_F00D, 0, 1, "t3_wr_vs_inst");
    cyc_step(0, 1, 32'h0000_2000, 0, 4'h0, '0, '0, 1, 0, "t3_inst_retry");
    idle(0, 2);

    // T4: both held for 10 cycles -> D D D D I D D D D I
    for (int i = 0; i < 10; i++)
      cyc_step(0, 1, 32'h0000_3000 + 32'(i * 4), 1, 4'h0, 32'h8000_0100 + 32'(i * 4), '0,
               (i == 4 || i == 9), !(i == 4 || i == 9), "t4");
    idle(0, 2);

    // Dropping inst_req clears the starvation count
    for (int i = 0; i < 3; i++)
      cyc_step(0, 1, 32'h0000_4000, 1, 4'h0, 32'h8000_0200 + 32'(i * 4), '0, 0, 1, "drop_pre");
    cyc_step(0, 0, '0, 1, 4'h0, 32'h8000_0210, '0, 0, 1, "drop_gap");
    for (int i = 0; i < 5; i++)
      cyc_step(0, 1, 32'h0000_4000, 1, 4'h0, 32'h8000_0220 + 32'(i * 4), '0, (i == 4), (i != 4), "drop_post");
    idle(0, 2);

    // T5: MEM_LAT=3, reset right after a grant discards the response
    cyc_step(1, 1, 32'h0000_5000, 0, '0, '0, '0, 1, 0, "t5_grant");
    @(posedge clk);
    #1;
    b_reset = 1; b_inst_req = 0; b_data_req = 1; b_data_addr = 32'h8000_0300;
    for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].dut == 1) sb.delete(j);
    #2;
    chk("t5_data_ready", b_data_ready, 0);
    chk("t5_mem_en", b_mem_en, 0);
    chk("t5_mem_addr", b_mem_addr, 0);
    chk("t5_rvalid", {b_inst_rvalid, b_data_rvalid}, 0);
    @(posedge clk);
    #1;
    b_reset = 0; b_data_req = 0;
    idle(1, 6);

    // T6: MEM_LAT=3 alternating I/D grants, back to back, plus a contended pair and a store
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cyc_step(1, 1, 32'h0000_0100 + 32'(i * 4), 0, '0, '0, '0, 1, 0, "t6_i");
      else            cyc_step(1, 0, '0, 1, 4'h0, 32'h8000_0400 + 32'(i * 4), '0, 0, 1, "t6_d");
    end
    cyc_step(1, 1, 32'h0000_0200, 1, 4'h0, 32'h8000_0500, '0, 0, 1, "t6_both");
    cyc_step(1, 1, 32'h0000_0200, 0, 4'h0, '0, '0, 1, 0, "t6_inst");
    cyc_step(1, 0, '0, 1, 4'h1, 32'h8000_0600, 32'h0000_00AA, 0, 1, "t6_wr");
    idle(1, 5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
